// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: fetch FSM states and the IF/ID pipeline register
// layout, which the decode stage reuses.
package kgp_pkg;

    localparam int unsigned         KGP_XLEN = 32;
    localparam logic [KGP_XLEN-1:0] KGP_NOP  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } kgp_fetch_state_e;

    typedef struct packed {
        logic [KGP_XLEN-1:0] instr;
        logic [KGP_XLEN-1:0] pc;
        logic                valid;
    } kgp_ifid_t;

endpackage

// File: rtl/kgp_fetch_holdbuf.sv
// One-entry skid buffer that parks a fetched word while decode is stalled.
// Clear outranks load, load outranks drain.
module kgp_fetch_holdbuf
    import kgp_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      drain_i,
    input  logic      clear_i,
    input  kgp_ifid_t data_i,
    output logic      full_o,
    output kgp_ifid_t data_o
);

    logic      full_q;
    kgp_ifid_t data_q;

    // NOTE: the payload is reset as well as the flag, so a drain can never present X to IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/kgp_fetch_stage.sv
// KGP-RISC instruction fetch: PC, single-outstanding imem reads, IF/ID register.
// Optional performance counters are enabled by defining KGP_FETCH_PERF_EN.
module kgp_fetch_stage
    import kgp_pkg::*;
#(
    parameter logic [KGP_XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                pcsrc,
    input  logic [KGP_XLEN-1:0] target,
    output logic                imem_req,
    output logic [KGP_XLEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [KGP_XLEN-1:0] imem_rdata,
    output logic [KGP_XLEN-1:0] ifid_instr,
    output logic [KGP_XLEN-1:0] ifid_pc,
    output logic                ifid_valid
`ifdef KGP_FETCH_PERF_EN
    ,
    output logic [KGP_XLEN-1:0] perf_fetched,
    output logic [KGP_XLEN-1:0] perf_squashed
`endif
);

    kgp_fetch_state_e    state_q, state_d;
    logic [KGP_XLEN-1:0] pc_q, pc_d;
    logic [KGP_XLEN-1:0] addr_q, addr_d;
    logic                run_q;
    kgp_ifid_t           ifid_q, ifid_d;
    kgp_ifid_t           buf_d, buf_q;
    logic                buf_full, buf_load, buf_drain, buf_clear;
    logic                granted, deliver;
    logic [KGP_XLEN-1:0] redirect_pc;

    // run_q keeps the request low during reset and raises it one cycle after release.
    assign redirect_pc = {target[KGP_XLEN-1:2], 2'b00};
    assign imem_req    = run_q && (state_q == IDLE) && !buf_full;
    assign imem_addr   = pc_q;
    assign granted     = imem_req && imem_gnt;
    assign deliver     = (state_q == WAIT) && imem_rvalid;
    assign buf_d       = '{instr: imem_rdata, pc: addr_q, valid: 1'b1};

    // NOTE: every always_comb output gets a default before any branch, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        ifid_d    = ifid_q;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (granted) begin
                    addr_d  = pc_q;
                    pc_d    = pc_q + KGP_XLEN'(PC_STEP);
                    state_d = pcsrc ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) state_d = IDLE;
                else if (pcsrc)  state_d = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pcsrc) pc_d = redirect_pc;

        // A redirect beats a stall: the slot and the buffer both hold wrong-path words.
        if (pcsrc) begin
            ifid_d.valid = 1'b0;
            buf_clear    = 1'b1;
        end else if (stall) begin
            buf_load = deliver;
        end else if (buf_full) begin
            ifid_d       = buf_q;
            ifid_d.valid = 1'b1;
            buf_drain    = 1'b1;
        end else if (deliver) begin
            ifid_d = buf_d;
        end else begin
            ifid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            run_q   <= 1'b0;
            ifid_q  <= '{instr: KGP_NOP, pc: '0, valid: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            run_q   <= 1'b1;
            ifid_q  <= ifid_d;
        end
    end

    kgp_fetch_holdbuf u_holdbuf (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (buf_load),
        .drain_i(buf_drain),
        .clear_i(buf_clear),
        .data_i (buf_d),
        .full_o (buf_full),
        .data_o (buf_q)
    );

    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_valid = ifid_q.valid;

`ifdef KGP_FETCH_PERF_EN
    logic [KGP_XLEN-1:0] perf_fetched_q, perf_squashed_q;
    logic                fetch_inc;
    logic [1:0]          squash_n;

    // A redirect can discard the IF/ID word and a buffered or arriving word together.
    assign fetch_inc = !pcsrc && !stall && (buf_full || deliver);
    assign squash_n  = (pcsrc ? (2'(buf_full) + 2'(ifid_q.valid) + 2'(deliver)) : 2'd0)
                     + 2'((state_q == DROP) && imem_rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_q + KGP_XLEN'(fetch_inc);
            perf_squashed_q <= perf_squashed_q + KGP_XLEN'(squash_n);
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_kgp_fetch_stage.sv
// Directed bench for kgp_fetch_stage: a transaction-level model (outstanding read,
// hold queue, expected IF/ID) is checked every cycle, plus literal spot checks.
module tb_kgp_fetch_stage;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, pcsrc;
    logic [31:0] target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ifid_instr, ifid_pc;
    logic        ifid_valid;

    logic        req2;
    logic        rv2    = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic [31:0] addr2, instr2, pc2;
    logic        valid2;

`ifdef KGP_FETCH_PERF_EN
    logic [31:0] perf_f, perf_s, perf_f2, perf_s2;
`endif

    kgp_fetch_stage dut (
        .clk        (clk),
        .reset      (rst_n),
        .stall      (stall),
        .pcsrc      (pcsrc),
        .target     (target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_valid (ifid_valid)
`ifdef KGP_FETCH_PERF_EN
        ,
        .perf_fetched (perf_f),
        .perf_squashed(perf_s)
`endif
    );

    kgp_fetch_stage #(.RESET_PC(WRAP_PC), .PC_STEP(4)) dut_wrap (
        .clk        (clk),
        .reset      (rst_n),
        .stall      (1'b0),
        .pcsrc      (1'b0),
        .target     (32'h0),
        .imem_req   (req2),
        .imem_addr  (addr2),
        .imem_gnt   (1'b1),
        .imem_rvalid(rv2),
        .imem_rdata (rdata2),
        .ifid_instr (instr2),
        .ifid_pc    (pc2),
        .ifid_valid (valid2)
`ifdef KGP_FETCH_PERF_EN
        ,
        .perf_fetched (perf_f2),
        .perf_squashed(perf_s2)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pc, one outstanding read (stale after redirect), a hold queue, expected IF/ID.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } slot_t;
    bit          m_run, m_out, m_stale;
    logic [31:0] m_pc, m_out_addr;
    slot_t       m_held[$];
    logic [31:0] e_instr, e_pc;
    bit          e_valid;

    typedef struct { logic [31:0] addr; int due; } mrsp_t;
    mrsp_t       mem_q[$];
    logic [31:0] glog[$];
    logic [31:0] glog2[$];
    int          cyc_n  = 0;
    int          lat    = 1;
    logic [31:0] rd_xor = 32'h0;
    bit          stray  = 1'b0;

    function automatic bit e_req();
        return m_run && !m_out && (m_held.size() == 0);
    endfunction

    task automatic model_reset();
        m_run = 0; m_out = 0; m_stale = 0; m_pc = 32'h0; m_out_addr = 32'h0;
        m_held.delete();
        e_instr = 32'h0; e_pc = 32'h0; e_valid = 0;
        mem_q.delete();
    endtask

    // One clock cycle: apply inputs and memory response, advance model, land at negedge+1.
    task automatic cyc(input bit s, input bit p, input logic [31:0] t, input bit g_en);
        bit          granted, resp;
        logic [31:0] w;
        stall = s; pcsrc = p; target = t;
        imem_gnt    = imem_req && g_en;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc_n) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ rd_xor;
            void'(mem_q.pop_front());
        end else if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_0000;
        end
        if (imem_gnt) begin
            mem_q.push_back('{addr: imem_addr, due: cyc_n + lat});
            glog.push_back(imem_addr);
        end

        granted = e_req() && g_en;
        resp    = imem_rvalid && m_out;
        w       = m_out_addr ^ rd_xor;
        if (p) begin
            e_valid = 0;
            m_held.delete();
        end else if (s) begin
            if (resp && !m_stale) m_held.push_back('{instr: w, pc: m_out_addr});
        end else if (m_held.size() > 0) begin
            e_instr = m_held[0].instr; e_pc = m_held[0].pc; e_valid = 1;
            m_held.delete();
        end else if (resp && !m_stale) begin
            e_instr = w; e_pc = m_out_addr; e_valid = 1;
        end else begin
            e_valid = 0;
        end
        if (resp)             m_out = 0;
        else if (p && m_out)  m_stale = 1;
        if (granted) begin
            m_out = 1; m_out_addr = m_pc; m_stale = p;
        end
        if (p)            m_pc = {t[31:2], 2'b00};
        else if (granted) m_pc = m_pc + 32'd4;
        m_run = 1;

        cyc_n++;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req",   imem_req,   e_req());
            check("imem_addr",  imem_addr,  m_pc);
            check("ifid_valid", ifid_valid, e_valid);
            check("ifid_pc",    ifid_pc,    e_pc);
            check("ifid_instr", ifid_instr, e_instr);
        end
    end

    // Zero-wait responder for the wrap instance: grant always, data the next cycle.
    bit          seen2 = 1'b0;
    logic [31:0] seen_addr2 = 32'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rv2   = 1'b0;
            seen2 = 1'b0;
        end else begin
            rv2        = seen2;
            rdata2     = seen_addr2;
            seen2      = req2;
            seen_addr2 = addr2;
            if (req2) glog2.push_back(addr2);
        end
    end

    initial begin
        rst_n = 1'b0; stall = 0; pcsrc = 0; target = 32'h0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
        model_reset();
        @(negedge clk); #1;
        check("rst_req",   imem_req,   32'h0);
        check("rst_addr",  imem_addr,  32'h0);
        check("rst_valid", ifid_valid, 32'h0);
        check("rst_pc",    ifid_pc,    32'h0);
        check("rst_instr", ifid_instr, 32'h0);
        rst_n = 1'b1; chk_en = 1'b1;

        // Zero-wait fetch of 0, 4, 8 with rdata = addr.
        repeat (3) cyc(0, 0, 32'h0, 1);
        check("f0_valid", ifid_valid, 32'h1);
        check("f0_pc",    ifid_pc,    32'h0);
        cyc(0, 0, 32'h0, 1);
        check("f0_bubble", ifid_valid, 32'h0);
        cyc(0, 0, 32'h0, 1);
        check("f1_pc",    ifid_pc,    32'h4);
        check("f1_instr", ifid_instr, 32'h4);
        check("f1_valid", ifid_valid, 32'h1);

        // Word at 8 returns under a 3-cycle stall.
        cyc(0, 0, 32'h0, 1);
        check("grant_n", glog.size() >= 3, 32'h1);
        if (glog.size() >= 3) begin
            check("req_addr0", glog[0], 32'h0);
            check("req_addr1", glog[1], 32'h4);
            check("req_addr2", glog[2], 32'h8);
        end
        repeat (3) begin
            cyc(1, 0, 32'h0, 1);
            check("stall_noreq", imem_req, 32'h0);
        end
        check("stall_hold_pc", ifid_pc, 32'h4);
        cyc(0, 0, 32'h0, 1);
        check("drain_pc",    ifid_pc,    32'h8);
        check("drain_valid", ifid_valid, 32'h1);

        // Redirect while waiting on pc 12: its word is dropped.
        lat = 3;
        cyc(0, 0, 32'h0, 1);
        lat = 1;
        cyc(0, 1, 32'h100, 1);
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        check("drop_valid", ifid_valid, 32'h0);
        check("drop_pc",    ifid_pc,    32'h8);
        check("redir_req",  imem_req,   32'h1);
        check("redir_addr", imem_addr,  32'h100);

        rd_xor = 32'hDEAD_0000;
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        check("t100_instr", ifid_instr, 32'hDEAD_0100);

        // Stall fills the buffer, then redirect with stall still high flushes everything.
        cyc(1, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 1);
        check("buf_full_noreq", imem_req, 32'h0);
        cyc(1, 1, 32'h203, 1);
        check("flush_valid", ifid_valid, 32'h0);
        check("flush_req",   imem_req,   32'h1);
        check("flush_addr",  imem_addr,  32'h200);

        // Redirect in the same cycle as a grant.
        cyc(0, 1, 32'h300, 1);
        check("gr_redir_req",  imem_req,  32'h0);
        check("gr_redir_addr", imem_addr, 32'h300);
        cyc(0, 0, 32'h0, 1);
        check("gr_drop_valid", ifid_valid, 32'h0);

        // Grant withheld for two cycles, then normal fetch.
        cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 0);
        check("nogrant_addr", imem_addr, 32'h300);
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        check("t300_pc",    ifid_pc,    32'h300);
        check("t300_instr", ifid_instr, 32'hDEAD_0300);

        // Asynchronous reset while a slow read is outstanding.
        lat = 3;
        cyc(0, 0, 32'h0, 1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",   imem_req,   32'h0);
        check("arst_addr",  imem_addr,  32'h0);
        check("arst_valid", ifid_valid, 32'h0);
        check("arst_pc",    ifid_pc,    32'h0);
        check("arst_instr", ifid_instr, 32'h0);
        model_reset();
        lat = 1;
        @(negedge clk); #1;
        rst_n = 1'b1; chk_en = 1'b1;
        stray = 1'b1;
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        check("stray_ignored", ifid_valid, 32'h0);
        stray = 1'b0;
        cyc(0, 0, 32'h0, 1);
        check("post_rst_pc",    ifid_pc,    32'h0);
        check("post_rst_instr", ifid_instr, 32'hDEAD_0000);
        repeat (3) cyc(0, 0, 32'h0, 1);
        chk_en = 1'b0;

        // Wrap instance: FFFF_FFFC + 4 wraps to 0.
        check("wrap_n", glog2.size() >= 3, 32'h1);
        if (glog2.size() >= 3) begin
            check("wrap_addr0", glog2[0], 32'hFFFF_FFFC);
            check("wrap_addr1", glog2[1], 32'h0000_0000);
            check("wrap_addr2", glog2[2], 32'h0000_0004);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
